// File: rtl/tp84_vol_lpf.sv
// TP84 output-stage model: decimates the sound mix to one sample per DIV clocks and low-pass filters it.
// Define TP84_VOLLPF_2POLE_EN to cascade a second identical pole through the same multiplier.
module tp84_vol_lpf #(
  parameter int DIV   = 298,
  parameter int COEF0 = 32767,
  parameter int COEF1 = 14000,
  parameter int COEF2 = 6000,
  parameter int COEF3 = 2500
) (
  input  logic        clk_14m,
  input  logic        n_reset,
  input  logic [1:0]  vol,
  input  logic        mute,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        out_valid
);

  // state | meaning
  // IDLE  | wait for tick; capture x and alpha
  // DIFF  | diff = x*2^15 - y
  // MUL   | prod = diff * alpha
  // ACC   | y += prod >>> 15
  // DIFF2 | diff = y - y2            (two-pole build)
  // MUL2  | prod = diff * alpha      (two-pole build)
  // ACC2  | y2 += prod >>> 15        (two-pole build)
  // OUT   | out = sat(last pole), pulse out_valid
`ifdef TP84_VOLLPF_2POLE_EN
  typedef enum logic [2:0] {IDLE, DIFF, MUL, ACC, DIFF2, MUL2, ACC2, OUT} state_t;
`else
  typedef enum logic [2:0] {IDLE, DIFF, MUL, ACC, OUT} state_t;
`endif

  state_t             state_q, state_d;
  logic [9:0]         cnt_q, cnt_d;
  logic [15:0]        x_q, x_d;
  logic [14:0]        alpha_q, alpha_d;
  logic signed [30:0] y_q, y_d;
  logic signed [31:0] diff_q, diff_d;
  logic signed [47:0] prod_q, prod_d;
  logic [15:0]        out_q, out_d;
  logic               out_valid_q, out_valid_d;
`ifdef TP84_VOLLPF_2POLE_EN
  logic signed [30:0] y2_q, y2_d;
`endif

  logic               tick;
  logic signed [47:0] mult;
  logic               unused_prod;

  function automatic logic [14:0] coef_sel(input logic [1:0] v);
    case (v)
      2'd0:    return 15'(COEF0);
      2'd1:    return 15'(COEF1);
      2'd2:    return 15'(COEF2);
      default: return 15'(COEF3);
    endcase
  endfunction

  // A 31-bit Q16.15 value always fits after the shift; the clamp only guards against future widening.
  function automatic logic [15:0] sat16(input logic signed [30:0] acc);
    logic signed [16:0] v;
    v = {acc[30], acc[30:15]};
    if (v > 17'sd32767)
      return 16'h7FFF;
    else if (v < -17'sd32768)
      return 16'h8000;
    return v[15:0];
  endfunction

  assign tick        = (cnt_q == 10'(DIV - 1));
  assign mult        = $signed({{16{diff_q[31]}}, diff_q}) * $signed({33'd0, alpha_q});
  assign unused_prod = ^{prod_q[47:46], prod_q[14:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = tick ? 10'd0 : cnt_q + 10'd1;
    x_d         = x_q;
    alpha_d     = alpha_q;
    y_d         = y_q;
    diff_d      = diff_q;
    prod_d      = prod_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
`ifdef TP84_VOLLPF_2POLE_EN
    y2_d        = y2_q;
`endif
    case (state_q)
      IDLE: begin
        if (tick) begin
          x_d     = mute ? 16'd0 : in;
          alpha_d = coef_sel(vol);
          state_d = DIFF;
        end
      end
      DIFF: begin
        diff_d  = $signed({x_q[15], x_q, 15'd0}) - $signed({y_q[30], y_q});
        state_d = MUL;
      end
      MUL: begin
        prod_d  = mult;
        state_d = ACC;
      end
      ACC: begin
        y_d = y_q + $signed(prod_q[45:15]);
`ifdef TP84_VOLLPF_2POLE_EN
        state_d = DIFF2;
`else
        state_d = OUT;
`endif
      end
`ifdef TP84_VOLLPF_2POLE_EN
      DIFF2: begin
        diff_d  = $signed({y_q[30], y_q}) - $signed({y2_q[30], y2_q});
        state_d = MUL2;
      end
      MUL2: begin
        prod_d  = mult;
        state_d = ACC2;
      end
      ACC2: begin
        y2_d    = y2_q + $signed(prod_q[45:15]);
        state_d = OUT;
      end
`endif
      OUT: begin
`ifdef TP84_VOLLPF_2POLE_EN
        out_d = sat16(y2_q);
`else
        out_d = sat16(y_q);
`endif
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_14m) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      alpha_q     <= 15'(COEF0);
      y_q         <= '0;
      diff_q      <= '0;
      prod_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef TP84_VOLLPF_2POLE_EN
      y2_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      alpha_q     <= alpha_d;
      y_q         <= y_d;
      diff_q      <= diff_d;
      prod_q      <= prod_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef TP84_VOLLPF_2POLE_EN
      y2_q        <= y2_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
